// File: rtl/sub_bytes_engine.sv
// Multi-lane AES SubBytes / InvSubBytes engine: LANES S-boxes walk a DATA_BYTES block over BEATS cycles.
// Optional delivered-block counter (blk_count port) is built when SUB_BYTES_CNT_EN is defined.
//
// state | meaning
// IDLE  | waiting for a block, in_ready=1
// BUSY  | substituting LANES bytes per cycle, beat counter advancing
// DONE  | result presented on out_data until out_ready
module sub_bytes_engine #(
  parameter int DATA_BYTES = 16,
  parameter int LANES      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_mode,
  input  logic [8*DATA_BYTES-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [8*DATA_BYTES-1:0] out_data
`ifdef SUB_BYTES_CNT_EN
  ,
  output logic [31:0]             blk_count
`endif
);

  localparam int BEATS = DATA_BYTES / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  // Table byte for index x sits at bit offset 8*(255-x): row 0 is written first.
  localparam logic [2047:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    return SBOX_FWD[(255 - int'(x))*8 +: 8];
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    return SBOX_INV[(255 - int'(x))*8 +: 8];
  endfunction

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        beat_q, beat_d;
  logic                    mode_q, mode_d;
  logic [8*DATA_BYTES-1:0] data_q, data_d;
  logic [7:0]              lane_in  [LANES];
  logic [7:0]              lane_out [LANES];

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_in[l]  = data_q[(int'(beat_q)*LANES + l)*8 +: 8];
      lane_out[l] = mode_q ? sbox_inv(lane_in[l]) : sbox_fwd(lane_in[l]);
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    mode_d    = mode_q;
    data_d    = data_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = in_data;
          mode_d  = in_mode;
          beat_d  = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int l = 0; l < LANES; l++) begin
          data_d[(int'(beat_q)*LANES + l)*8 +: 8] = lane_out[l];
        end
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = DONE;
        end else begin
          beat_d = beat_q + CNT_W'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Gate the data register so partially substituted bytes never appear on the output.
  assign out_data = (state_q == DONE) ? data_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      mode_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
    end
  end

`ifdef SUB_BYTES_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign blk_count = cnt_q;
`endif

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Self-checking bench for sub_bytes_engine: scoreboard against an S-box derived from GF(2^8) arithmetic.
// Extra instances with LANES=1,2,16 share the stimulus for the latency sweep.
module tb_sub_bytes_engine;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_mode = 1'b0;
  logic [127:0] in_data = '0;
  logic         out_ready = 1'b1;

  logic         in_ready, out_valid;
  logic [127:0] out_data;
  logic         l1_in_ready, l1_out_valid, l2_in_ready, l2_out_valid, l16_in_ready, l16_out_valid;
  logic [127:0] l1_out_data, l2_out_data, l16_out_data;
`ifdef SUB_BYTES_CNT_EN
  logic [31:0]  blk_count, l1_blk_count, l2_blk_count, l16_blk_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [127:0] sb[$];
  logic [7:0]   m_fwd [256];
  logic [7:0]   m_inv [256];

  always #5 clk = ~clk;

  sub_bytes_engine #(.DATA_BYTES(16), .LANES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef SUB_BYTES_CNT_EN
    , .blk_count(blk_count)
`endif
  );

  sub_bytes_engine #(.DATA_BYTES(16), .LANES(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(l1_in_ready), .in_mode(in_mode),
    .in_data(in_data), .out_valid(l1_out_valid), .out_ready(out_ready), .out_data(l1_out_data)
`ifdef SUB_BYTES_CNT_EN
    , .blk_count(l1_blk_count)
`endif
  );

  sub_bytes_engine #(.DATA_BYTES(16), .LANES(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(l2_in_ready), .in_mode(in_mode),
    .in_data(in_data), .out_valid(l2_out_valid), .out_ready(out_ready), .out_data(l2_out_data)
`ifdef SUB_BYTES_CNT_EN
    , .blk_count(l2_blk_count)
`endif
  );

  sub_bytes_engine #(.DATA_BYTES(16), .LANES(16)) u_l16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(l16_in_ready), .in_mode(in_mode),
    .in_data(in_data), .out_valid(l16_out_valid), .out_ready(out_ready), .out_data(l16_out_data)
`ifdef SUB_BYTES_CNT_EN
    , .blk_count(l16_blk_count)
`endif
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
    return (v << k) | (v >> (8 - k));
  endfunction

  task automatic build_model();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      m_fwd[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) m_inv[m_fwd[x]] = 8'(x);
  endtask

  function automatic logic [127:0] model(input logic [127:0] d, input logic m);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = m ? m_inv[d[8*i +: 8]] : m_fwd[d[8*i +: 8]];
    return r;
  endfunction

  task automatic send_block(input logic [127:0] d, input logic m, output time t_acc);
    int n;
    n = 0;
    in_data  = d;
    in_mode  = m;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
    end
    sb.push_back(model(d, m));
    @(posedge clk);
    t_acc = $time;
    #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    in_mode  = ~m;
  endtask

  task automatic recv_block(input string name, output logic [127:0] got, output int lat);
    logic [127:0] exp;
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    lat = n;
    got = out_data;
    checks++;
    if (n >= 100 || sb.size() == 0) begin
      errors++;
      $display("FAIL %s_recv: out_valid=%b after %0d cycles, queue=%0d, required a block", name, out_valid, n, sb.size());
    end else begin
      exp = sb.pop_front();
      if (out_data !== exp) begin
        errors++;
        $display("FAIL %s_data: got %h required %h", name, out_data, exp);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 128'h0) begin
      errors++;
      $display("FAIL reset_out: out_valid=%b out_data=%h required 0/0", out_valid, out_data);
    end
`ifdef SUB_BYTES_CNT_EN
    checks++;
    if (blk_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_cnt: blk_count=%0d required 0", blk_count);
    end
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_known_vectors();
    logic [127:0] got;
    int lat;
    time t;
    send_block(128'h0, 1'b0, t);
    recv_block("zero_fwd", got, lat);
    checks++;
    if (got !== {16{8'h63}} || lat != 4) begin
      errors++;
      $display("FAIL zero_fwd_const: got %h lat %0d required all 63 lat 4", got, lat);
    end
    send_block({16{8'h63}}, 1'b1, t);
    recv_block("x63_inv", got, lat);
    checks++;
    if (got !== 128'h0) begin
      errors++;
      $display("FAIL x63_inv_const: got %h required 0", got);
    end
    send_block(128'h53, 1'b0, t);
    recv_block("x53_fwd", got, lat);
    checks++;
    if (got[7:0] !== 8'hed) begin
      errors++;
      $display("FAIL x53_fwd_const: got %h required ed", got[7:0]);
    end
    send_block(128'h0, 1'b1, t);
    recv_block("zero_inv", got, lat);
    checks++;
    if (got[7:0] !== 8'h52) begin
      errors++;
      $display("FAIL zero_inv_const: got %h required 52", got[7:0]);
    end
  endtask

  task automatic test_round_trip();
    logic [127:0] orig [16];
    logic [127:0] enc  [16];
    logic [127:0] got;
    int lat;
    time t;
    for (int b = 0; b < 16; b++) begin
      for (int i = 0; i < 16; i++) orig[b][8*i +: 8] = 8'(b*16 + i);
      send_block(orig[b], 1'b0, t);
      recv_block("sweep_fwd", enc[b], lat);
    end
    for (int b = 0; b < 16; b++) begin
      send_block(enc[b], 1'b1, t);
      recv_block("sweep_inv", got, lat);
      checks++;
      if (got !== orig[b]) begin
        errors++;
        $display("FAIL round_trip_%0d: got %h required %h", b, got, orig[b]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] got;
    int lat;
    time t1, t2;
    send_block({$urandom, $urandom, $urandom, $urandom}, 1'b0, t1);
    recv_block("b2b_a", got, lat);
    send_block({$urandom, $urandom, $urandom, $urandom}, 1'b1, t2);
    recv_block("b2b_b", got, lat);
    checks++;
    if (t2 - t1 != 60) begin
      errors++;
      $display("FAIL b2b_period: accept spacing %0t required 60", t2 - t1);
    end
  endtask

  task automatic test_back_pressure();
    logic [127:0] exp;
    int n;
    time t;
    out_ready = 1'b0;
    send_block({$urandom, $urandom, $urandom, $urandom}, 1'b0, t);
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    exp = sb.pop_front();
    in_valid = 1'b1;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp) begin
        errors++;
        $display("FAIL bp_hold_%0d: valid=%b ready=%b data=%h required 1/0/%h", c, out_valid, in_ready, out_data, exp);
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: valid=%b ready=%b required 0/1", out_valid, in_ready);
    end
    n = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid === 1'b1) n++;
      @(posedge clk); #1;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL bp_no_extra: %0d stray out_valid cycles, required 0", n);
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [127:0] got;
    int lat;
    time t;
    send_block({$urandom, $urandom, $urandom, $urandom}, 1'b0, t);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 128'h0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b data=%h required 0/0", out_valid, out_data);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send_block({$urandom, $urandom, $urandom, $urandom}, 1'b1, t);
    recv_block("after_reset", got, lat);
  endtask

  task automatic test_latency_sweep();
    logic [127:0] d, exp, got;
    logic m;
    int lat1, lat2, lat4, lat16, lat;
    time t;
    do_reset();
    out_ready = 1'b1;
    d = {$urandom, $urandom, $urandom, $urandom};
    m = 1'($urandom_range(0, 1));
    exp = model(d, m);
    lat1 = 0; lat2 = 0; lat4 = 0; lat16 = 0;
    in_data = d; in_mode = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (l1_out_valid === 1'b1 && lat1 == 0) begin
        lat1 = n; checks++;
        if (l1_out_data !== exp) begin errors++; $display("FAIL l1_data: got %h required %h", l1_out_data, exp); end
      end
      if (l2_out_valid === 1'b1 && lat2 == 0) begin
        lat2 = n; checks++;
        if (l2_out_data !== exp) begin errors++; $display("FAIL l2_data: got %h required %h", l2_out_data, exp); end
      end
      if (out_valid === 1'b1 && lat4 == 0) begin
        lat4 = n; checks++;
        if (out_data !== exp) begin errors++; $display("FAIL l4_data: got %h required %h", out_data, exp); end
      end
      if (l16_out_valid === 1'b1 && lat16 == 0) begin
        lat16 = n; checks++;
        if (l16_out_data !== exp) begin errors++; $display("FAIL l16_data: got %h required %h", l16_out_data, exp); end
      end
    end
    checks++;
    if (lat1 != 16 || lat2 != 8 || lat4 != 4 || lat16 != 1) begin
      errors++;
      $display("FAIL latency: l1=%0d l2=%0d l4=%0d l16=%0d required 16/8/4/1", lat1, lat2, lat4, lat16);
    end
    send_block({$urandom, $urandom, $urandom, $urandom}, 1'b0, t);
    recv_block("cnt_b", got, lat);
    send_block({$urandom, $urandom, $urandom, $urandom}, 1'b1, t);
    recv_block("cnt_c", got, lat);
`ifdef SUB_BYTES_CNT_EN
    checks++;
    if (blk_count !== 32'd3) begin
      errors++;
      $display("FAIL blk_count: got %0d required 3", blk_count);
    end
`endif
  endtask

  initial begin
    build_model();
    test_reset();
    test_known_vectors();
    test_round_trip();
    test_back_to_back();
    test_back_pressure();
    test_reset_mid_busy();
    test_latency_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
